// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for every register-file write source.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // One register-file write: valid strobe, destination and payload.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  typedef enum logic {
    StIdle,
    StStall
  } stall_state_e;

endpackage

// File: rtl/regfile_wr_queue.sv
// Circular buffer of deferred register writes. Each slot carries a live bit so
// that a younger write to the same register can cancel it without reordering
// the buffer; cancelled slots still drain through the head in order.
module regfile_wr_queue
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  wr_req_t               push_req_i,  // valid doubles as the push strobe
  input  logic                  pop_i,       // only asserted while not empty
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_reg_i,
  output wr_req_t               head_o,      // valid = head slot still live
  output logic                  empty_o,
  output logic                  full_o,
  output logic [NUM_REGS-1:0]   pending_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DEPTH-1:0]      live_q, live_d;
  logic [REG_ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));

  assign head_o = '{valid:    live_q[rd_ptr_q],
                    reg_addr: reg_q[rd_ptr_q],
                    data:     data_q[rd_ptr_q]};

  // Next-state for pointers, occupancy and live bits; kill is applied before
  // the push so an entry entering this edge is never cancelled by itself.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    live_d   = live_q;
    if (kill_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (reg_q[i] == kill_reg_i) live_d[i] = 1'b0;
      end
    end
    if (pop_i) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PtrW'(1);
    end
    if (push_req_i.valid) begin
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    case ({push_req_i.valid, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register; reset discards every stored entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      if (push_req_i.valid) begin
        reg_q[wr_ptr_q]  <= push_req_i.reg_addr;
        data_q[wr_ptr_q] <= push_req_i.data;
      end
    end
  end

  // Pending bitmap: one bit per register with a live queued write.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live_q[i]) pending_o[reg_q[i]] = 1'b1;
    end
    pending_o[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the writeback stage (A, fixed
// priority, no backpressure) and a queued multi-cycle source (B). Raises a
// stall request when B has been locked out for too long.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  A_Valid,
  input  logic [REG_ADDR_W-1:0] A_Reg,
  input  logic [DATA_W-1:0]     A_Data,
  input  logic                  B_Valid,
  output logic                  B_Ready,
  input  logic [REG_ADDR_W-1:0] B_Reg,
  input  logic [DATA_W-1:0]     B_Data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0]     WriteData,
  output logic [NUM_REGS-1:0]   Pending,
  output logic                  Stall_Req
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  wr_req_t               push_req;
  wr_req_t               head;
  logic                  q_empty, q_full;
  logic                  a_write, pop;
  wr_req_t               out_q, out_d;
  logic [StarveW-1:0]    starve_q, starve_d;
  stall_state_e          state_q, state_d;
  logic                  pop_q;

  assign B_Ready = !q_full;
  // A with register 0 still owns the port this edge; it just writes nothing.
  assign a_write = A_Valid && (A_Reg != ZERO_REG);
  assign pop     = !A_Valid && !q_empty;

  // Writes to register 0 are accepted from B but dropped on the floor.
  assign push_req = '{valid:    B_Valid && B_Ready && (B_Reg != ZERO_REG),
                      reg_addr: B_Reg,
                      data:     B_Data};

  regfile_wr_queue #(
    .DEPTH (DEPTH)
  ) u_wr_queue (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .push_req_i (push_req),
    .pop_i      (pop),
    .kill_i     (a_write),
    .kill_reg_i (A_Reg),
    .head_o     (head),
    .empty_o    (q_empty),
    .full_o     (q_full),
    .pending_o  (Pending)
  );

  // Port grant; address and data hold their last value when nothing is written.
  always_comb begin
    out_d       = out_q;
    out_d.valid = 1'b0;
    if (A_Valid) begin
      if (a_write) out_d = '{valid: 1'b1, reg_addr: A_Reg, data: A_Data};
    end else if (pop && head.valid) begin
      out_d = head;
    end
  end

  // Starvation counter: counts edges where B is waiting and A holds the port.
  always_comb begin
    starve_d = '0;
    if (A_Valid && !q_empty) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1);
    end
  end

  // Stall FSM next state; leaves STALL one edge after B gets a pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (starve_d == StarveMax) state_d = StStall;
      StStall: if (pop_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign Stall_Req = (state_q == StStall);

  // Output, counter and FSM registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      out_q    <= '0;
      starve_q <= '0;
      state_q  <= StIdle;
      pop_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      starve_q <= starve_d;
      state_q  <= state_d;
      pop_q    <= pop;
    end
  end

  assign RegWrite      = out_q.valid;
  assign WriteRegister = out_q.reg_addr;
  assign WriteData     = out_q.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised bench with a queue-based reference model and a write scoreboard.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        A_Valid = 1'b0, B_Valid = 1'b0;
  logic [4:0]  A_Reg = '0, B_Reg = '0;
  logic [31:0] A_Data = '0, B_Data = '0;
  logic        B_Ready, RegWrite, Stall_Req;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] Pending;

  regfile_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .A_Valid       (A_Valid),
    .A_Reg         (A_Reg),
    .A_Data        (A_Data),
    .B_Valid       (B_Valid),
    .B_Ready       (B_Ready),
    .B_Reg         (B_Reg),
    .B_Data        (B_Data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Pending       (Pending),
    .Stall_Req     (Stall_Req)
  );

  always #5 Clk = ~Clk;

  typedef struct {logic [4:0] r; logic [31:0] d; bit live;} qent_t;
  typedef struct {logic [4:0] r; logic [31:0] d; int stamp;} exp_t;

  qent_t mq[$];   // model of B's queued writes, oldest first
  exp_t  sb[$];   // expected port writes with the edge that launches them
  int    checks = 0;
  int    errors = 0;
  int    edge_cnt = 0;
  int    starve = 0;
  bit    stall = 0;
  bit    popped_prev = 0;
  logic [31:0] rf [32] = '{default: 32'h0};

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // Simple register file fed by the DUT port.
  always @(posedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;

  always @(posedge Clk) begin
    if (Rst) assert (!(Stall_Req && A_Valid)) else $error("protocol violation: A_Valid during Stall_Req");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) if (mq[i].live) p[mq[i].r] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Called at a falling edge: check visible state, drive one cycle, advance model.
  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit bv, input logic [4:0] br, input logic [31:0] bd);
    int    old;
    bit    full, popped;
    qent_t e;
    check("pending", Pending, model_pending());
    check("b_ready", B_Ready, mq.size() < DEPTH);
    check("stall_req", Stall_Req, stall);
    if (stall) av = 1'b0;
    A_Valid = av; A_Reg = ar; A_Data = ad;
    B_Valid = bv; B_Reg = br; B_Data = bd;
    old    = mq.size();
    full   = (old == DEPTH);
    popped = 1'b0;
    if (av) begin
      if (ar != 0) begin
        sb.push_back('{ar, ad, edge_cnt + 1});
        foreach (mq[i]) if (mq[i].r == ar) mq[i].live = 1'b0;
      end
    end else if (old > 0) begin
      e = mq.pop_front();
      popped = 1'b1;
      if (e.live) sb.push_back('{e.r, e.d, edge_cnt + 1});
    end
    if (bv && !full && br != 0) mq.push_back('{br, bd, 1'b1});
    starve = (old > 0 && av) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
    if (!stall && starve == LIMIT) stall = 1'b1;
    else if (stall && popped_prev) stall = 1'b0;
    popped_prev = popped;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  // Monitor: every write on the port must be the next expected one, on time.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      if (RegWrite) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual=r%0d:%0h required=none", WriteRegister, WriteData);
        end else begin
          e = sb.pop_front();
          if (WriteRegister !== e.r || WriteData !== e.d || edge_cnt != e.stamp) begin
            errors++;
            $display("FAIL port_write actual=r%0d:%0h@%0d required=r%0d:%0h@%0d",
                     WriteRegister, WriteData, edge_cnt, e.r, e.d, e.stamp);
          end
        end
      end else if (sb.size() > 0 && sb[0].stamp <= edge_cnt) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing_write actual=none required=r%0d:%0h@%0d", e.r, e.d, e.stamp);
      end
    end
  end

  initial begin
    #1;
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_wreg", WriteRegister, 5'd0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_pending", Pending, 32'h0);
    check("rst_b_ready", B_Ready, 1'b1);
    check("rst_stall", Stall_Req, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // A write to r9 lands one cycle after sampling.
    step(1, 5'd9, 32'hAA, 0, 5'd0, 32'h0);
    idle(2);
    check("rf_r9", rf[9], 32'hAA);

    // B r12 through the queue with A idle.
    step(0, 5'd0, 32'h0, 1, 5'd12, 32'h1234);
    idle(3);
    check("rf_r12", rf[12], 32'h1234);

    // Fill the queue while A hogs the port until the stall request appears.
    step(1, 5'd1, 32'h11, 1, 5'd13, 32'h1313);
    step(1, 5'd2, 32'h22, 1, 5'd14, 32'h1414);
    for (int i = 0; i < 6; i++) step(1, 5'd3, 32'h30 + i, 0, 5'd0, 32'h0);
    idle(4);
    check("rf_r13", rf[13], 32'h1313);
    check("rf_r14", rf[14], 32'h1414);

    // WAW kill: queued r15=5 cancelled by the younger A write r15=7.
    step(1, 5'd3, 32'h3, 1, 5'd15, 32'h5);
    step(1, 5'd15, 32'h7, 0, 5'd0, 32'h0);
    idle(3);
    check("rf_r15", rf[15], 32'h7);

    // Register 0 from both sides never writes.
    step(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
    idle(3);
    check("rf_r0", rf[0], 32'h0);

    // Reset with two queued entries.
    step(1, 5'd4, 32'h44, 1, 5'd20, 32'h2020);
    step(1, 5'd5, 32'h55, 1, 5'd21, 32'h2121);
    A_Valid = 0; B_Valid = 0;
    #1 Rst = 1'b0;
    #1;
    check("midrst_regwrite", RegWrite, 1'b0);
    check("midrst_pending", Pending, 32'h0);
    check("midrst_b_ready", B_Ready, 1'b1);
    check("midrst_stall", Stall_Req, 1'b0);
    mq.delete(); sb.delete();
    starve = 0; stall = 0; popped_prev = 0;
    @(posedge Clk);
    #2 Rst = 1'b1;
    @(negedge Clk);
    idle(5);
    check("rf_r20_untouched", rf[20], 32'h0);
    check("rf_r21_untouched", rf[21], 32'h0);

    // Random traffic on a small register set to provoke collisions and stalls.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    idle(10);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
